// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited sequential fetches,
// queues returned words with their PCs and hands them to decode; redirects flush and drop stale responses.
module if_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            id_ready,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } q_ent_t;

    q_ent_t          r_q [FIFO_DEPTH];
    logic [AW-1:0]   r_wp, r_rp;
    logic [CW-1:0]   r_cnt, r_out, r_drop;
    logic [XLEN-1:0] r_pc, r_resp_pc;
    logic            r_run;

    logic [CW+1:0]   w_inflight;
    logic            w_acc, w_keep, w_drop_rsp, w_push, w_pop;
    logic [XLEN-1:0] w_redir_pc;

    // Every issued request (live or stale) plus every queued word holds a slot,
    // so a response can never find the queue full.
    assign w_inflight = {2'b00, r_out} + {2'b00, r_drop} + {2'b00, r_cnt};
    assign imem_req_valid = r_run && !redirect_valid && (w_inflight < (CW+2)'(FIFO_DEPTH));
    assign imem_req_addr  = r_pc;

    assign w_acc      = imem_req_valid && imem_req_ready;
    assign w_keep     = imem_rsp_valid && (r_drop == '0);
    assign w_drop_rsp = imem_rsp_valid && (r_drop != '0);
    assign w_push     = w_keep && !redirect_valid;
    assign w_pop      = (r_cnt != '0) && id_ready && !redirect_valid;
    assign w_redir_pc = redirect_pc & ~XLEN'(3);

    assign if_valid = (r_cnt != '0);
    assign if_instr = if_valid ? r_q[r_rp].instr : '0;
    assign if_pc    = if_valid ? r_q[r_rp].pc    : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run     <= 1'b0;
            r_pc      <= RESET_PC;
            r_resp_pc <= RESET_PC;
            r_out     <= '0;
            r_drop    <= '0;
            r_cnt     <= '0;
            r_wp      <= '0;
            r_rp      <= '0;
        end else begin
            r_run <= 1'b1;
            if (redirect_valid) begin
                // A response landing now is stale either way and consumes one pending slot.
                r_pc      <= w_redir_pc;
                r_resp_pc <= w_redir_pc;
                r_drop    <= r_drop + r_out - CW'(imem_rsp_valid);
                r_out     <= '0;
                r_cnt     <= '0;
                r_wp      <= '0;
                r_rp      <= '0;
            end else begin
                if (w_acc)
                    r_pc <= r_pc + XLEN'(4);
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + XLEN'(4);
                    r_wp      <= r_wp + AW'(1);
                end
                if (w_pop)
                    r_rp <= r_rp + AW'(1);
                if (w_drop_rsp)
                    r_drop <= r_drop - CW'(1);
                r_out <= r_out + CW'(w_acc) - CW'(w_keep);
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_q[r_wp] <= '{pc: r_resp_pc, instr: imem_rsp_data};
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: an epoch-tagged memory model and an expected
// instruction queue predict every handshake and every word delivered to decode.
module tb_if_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_ready(id_ready),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        int          ep;
    } mitem_t;

    mitem_t      mem[$];
    logic [31:0] mq[$];
    logic [31:0] mpc;
    bit          run;
    int          epoch;
    int          nchk = 0;
    int          nerr = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        mem.delete();
        mq.delete();
        mpc   = 32'h0;
        run   = 1'b0;
        epoch++;
    endtask

    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy,
                         input logic idr, input logic rspen);
        logic   exp_rv, rsp;
        mitem_t h;
        @(negedge clk);
        chk("if_valid", {31'b0, if_valid}, {31'b0, mq.size() != 0});
        chk("if_pc",    if_pc,    (mq.size() != 0) ? mq[0] : 32'h0);
        chk("if_instr", if_instr, (mq.size() != 0) ? instr_of(mq[0]) : 32'h0);
        rsp            = rspen && (mem.size() != 0);
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        id_ready       = idr;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? instr_of(mem[0].a) : 32'hDEAD_BEEF;
        exp_rv         = run && !rv && ((mem.size() + mq.size()) < DEPTH);
        #1;
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv)
            chk("req_addr", imem_req_addr, mpc);
        @(posedge clk);
        h = '{a: 32'h0, ep: -1};
        if (rsp)
            h = mem.pop_front();
        if (rv) begin
            epoch++;
            mq.delete();
            mpc = {rpc[31:2], 2'b00};
        end else begin
            if (mq.size() != 0 && idr)
                void'(mq.pop_front());
            if (rsp && h.ep == epoch)
                mq.push_back(h.a);
            if (exp_rv && rdy) begin
                mem.push_back('{a: mpc, ep: epoch});
                mpc = mpc + 32'd4;
            end
        end
        run = 1'b1;
    endtask

    task automatic idle_inputs();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        id_ready       = 1'b0;
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] t;
            t = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            cycle($urandom_range(15) == 0, t, $urandom_range(3) != 0,
                  $urandom_range(3) != 0, $urandom_range(2) != 0);
        end
    endtask

    initial begin
        epoch = 0;
        rst   = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst_if_valid",  {31'b0, if_valid}, 32'h0);
        chk("rst_if_instr",  if_instr, 32'h0);
        chk("rst_if_pc",     if_pc, 32'h0);
        chk("rst_req_addr",  imem_req_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Streaming with 1-cycle memory and no stall.
        repeat (20) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        // Decode stall fills the queue, then releases.
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        // Two requests in flight, then redirect to 0x100.
        repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0);
        repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        // Redirect coinciding with a response.
        repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_0203, 1'b1, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        // Back-to-back redirects, last one wins; then PC wrap.
        cycle(1'b1, 32'h0000_4000, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 32'hFFFF_FFF9, 1'b1, 1'b1, 1'b1);
        repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

        rand_cycles(1500);

        // Asynchronous reset mid-stream.
        #2 rst = 1'b0;
        idle_inputs();
        #1;
        chk("mid_rst_if_valid",  {31'b0, if_valid}, 32'h0);
        chk("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("mid_rst_if_pc",     if_pc, 32'h0);
        chk("mid_rst_req_addr",  imem_req_addr, 32'h0);
        model_reset();
        #1 rst = 1'b1;
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        rand_cycles(800);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
